mem_responder: RTL and testbench

Memory-side responder for the multi-cycle CPU's data/instruction bus. It accepts one word read or write request at a time over a req/ack handshake and stalls for a parameterised number of wait states before completing. It owns a word-addressed RAM and flags misaligned accesses. It sits between the CPU core and the on-chip memory so the core can be verified against non-zero-latency memory.

---
 rtl/mem_responder.sv | 198 +++++++++++++++++++
 tb/tb_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: req/ack word-memory responder with WAIT wait states and misalignment flag.
// Optional debug read port built when MEM_RESPONDER_DBG_PORT_EN is defined.
module mem_responder #(
  parameter int ADDR_W = 9,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [31:0]       dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_C = 4'(WAIT);
  localparam int         DEPTH  = 1 << ADDR_W;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic                flag_r;
  logic                flag_nxt_s;
  logic                cap_s;
  logic                mis_s;
  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [31:0]         wdata_r;
  logic [31:0]         rdata_r;
  logic                ack_r;
  logic                err_r;
  logic                busy_r;
  logic [31:0]         mem_r [0:DEPTH-1];
  logic                unused_addr_s;

  assign mis_s         = (addr[1:0] != 2'b00);
  assign unused_addr_s = ^addr[31:ADDR_W+2];

  // Next-state, wait counter and error-flag decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    flag_nxt_s  = flag_r;
    cap_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req) begin
          cap_s = 1'b1;
          if (mis_s) begin
            state_nxt_s = S_RESP;
            flag_nxt_s  = 1'b1;
          end else if (WAIT_C != 4'd0) begin
            state_nxt_s = S_WAIT;
            cnt_nxt_s   = WAIT_C;
            flag_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = S_ACCESS;
            flag_nxt_s  = 1'b0;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = S_ACCESS;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_ACCESS: begin
        state_nxt_s = S_RESP;
        flag_nxt_s  = 1'b0;
      end
      S_RESP: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 4'd0;
        flag_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      flag_r  <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      flag_r  <= flag_nxt_s;
      ack_r   <= (state_nxt_s == S_RESP);
      err_r   <= (state_nxt_s == S_RESP) && flag_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
    end
  end

  // Request capture; later input changes do not affect the transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 32'd0;
    end else if (cap_s) begin
      we_r    <= we;
      waddr_r <= addr[ADDR_W+1:2];
      wdata_r <= wdata;
    end
  end

  // Read data only changes on an aligned read access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 32'd0;
    end else if ((state_r == S_ACCESS) && !we_r) begin
      rdata_r <= mem_r[waddr_r];
    end
  end

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if ((state_r == S_ACCESS) && we_r) begin
      mem_r[waddr_r] <= wdata_r;
    end
  end

`ifdef MEM_RESPONDER_DBG_PORT_EN
  logic [31:0] dbg_data_r;

  // Free-running debug read port, independent of the FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_data_r <= 32'd0;
    end else begin
      dbg_data_r <= mem_r[dbg_addr];
    end
  end

  assign dbg_data = dbg_data_r;
`else
  logic unused_dbg_s;
  assign unused_dbg_s = ^dbg_addr;
  assign dbg_data     = 32'd0;
`endif

  assign rdata = rdata_r;
  assign ack   = ack_r;
  assign err   = err_r;
  assign busy  = busy_r;

  mem_responder_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .ack  (ack_r),
    .err  (err_r),
    .busy (busy_r)
  );

endmodule

// Protocol properties of the responder outputs.
module mem_responder_chk (
  input logic clk,
  input logic rst,
  input logic ack,
  input logic err,
  input logic busy
);

  a_err_needs_ack : assert property (@(posedge clk) disable iff (!rst) err |-> ack)
    else $error("mem_responder_chk: err without ack");
  a_ack_pulse     : assert property (@(posedge clk) disable iff (!rst) ack |=> !ack)
    else $error("mem_responder_chk: ack longer than one cycle");
  a_ack_busy      : assert property (@(posedge clk) disable iff (!rst) ack |-> busy)
    else $error("mem_responder_chk: ack while not busy");

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table, hand sequences and a randomized
// phase checked against a word-array reference model.
module tb_mem_responder;

  localparam int AW     = 9;
  localparam int WAIT_N = 2;
  localparam int LAT    = WAIT_N + 2;

`ifdef MEM_RESPONDER_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, req0, we0;
  logic [31:0]   addr, wdata, addr0, wdata0;
  logic [31:0]   rdata, rdata0, dbg_data, dbg_data0;
  logic          ack, err, busy, ack0, err0, busy0;
  logic [AW-1:0] dbg_addr, dbg_addr0;

  int errors = 0;
  int checks = 0;
  int stray  = 0;

  logic [31:0] model [int];
  logic [31:0] last_rd;

  mem_responder #(.ADDR_W(AW), .WAIT(WAIT_N)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  mem_responder #(.ADDR_W(AW), .WAIT(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0),
    .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          lat;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference behaviour: latency, err and rdata from the access rules, not from FSM states.
  function automatic void model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     output int lat, output logic e, output logic [31:0] rd);
    int word;
    word = int'(a[AW+1:2]);
    if (a[1:0] != 2'b00) begin
      lat = 1; e = 1'b1; rd = last_rd;
    end else begin
      lat = LAT; e = 1'b0;
      if (w) begin
        model[word] = d;
        rd = last_rd;
      end else begin
        rd = model.exists(word) ? model[word] : 32'd0;
        last_rd = rd;
      end
    end
  endfunction

  // One transaction on either instance; returns ack latency, err, rdata and busy in T+1.
  task automatic txn(input bit s0, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic e, output logic [31:0] rd, output logic b1);
    logic a_s, e_s;
    lat = -1; e = 1'b0; rd = 32'd0; b1 = 1'b0;
    @(negedge clk);
    if (s0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        b1 = s0 ? busy0 : busy;
        if (s0) begin req0 = 1'b0; we0 = ~w; addr0 = $urandom; wdata0 = $urandom; end
        else    begin req  = 1'b0; we  = ~w; addr  = $urandom; wdata  = $urandom; end
      end
      a_s = s0 ? ack0 : ack;
      e_s = s0 ? err0 : err;
      if (!a_s && e_s) stray++;
      if (a_s) begin
        lat = n; e = e_s; rd = s0 ? rdata0 : rdata;
        break;
      end
    end
  endtask

  vec_t vecs [11];
  int   lat, exp_lat;
  logic e, exp_e, b1;
  logic [31:0] rd, exp_rd;
  int   k, acks;

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    dbg_addr = 9'd4; dbg_addr0 = 9'd1; last_rd = 32'd0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, LAT, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0013, 32'h1234_5678, 1,   1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0000_0004, 32'h0000_0002, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 32'h0000_0008, 32'h0000_0003, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_000C, 32'h0000_0004, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 32'h0000_0002, 32'h0000_0000, 1,   1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, LAT, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 32'hFFFF_F804, 32'h0000_0000, LAT, 1'b0, 32'h0000_0002};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dbg", dbg_data, 32'd0);
    check("rst_busy0", 32'(busy0), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    rst = 1'b1;

    // vector table
    for (int i = 0; i < 11; i++) begin
      model_step(vecs[i].w, vecs[i].a, vecs[i].d, exp_lat, exp_e, exp_rd);
      txn(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, lat, e, rd, b1);
      check("vec_lat", 32'(lat), 32'(vecs[i].lat));
      check("vec_err", 32'(e), 32'(vecs[i].e));
      check("vec_busy_t1", 32'(b1), 32'd1);
      if (i != 0) check("vec_rdata", rd, vecs[i].rd);
    end

    // back-to-back reads with req held high
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0; k = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("b2b_ack", 32'(ack), 32'((n % 5) == 4));
      check("b2b_busy", 32'(busy), 32'((n % 5) != 0));
      if (ack) begin
        check("b2b_rdata", rdata, 32'(k + 1));
        k++;
        if (k == 4) req = 1'b0;
        else addr = 32'(4 * k);
      end
    end
    last_rd = 32'd4;

    // reset during WAIT: write must be dropped
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA_5555;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_ack", 32'(ack), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    check("rstw_dbg", dbg_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rstw_no_ack", 32'(acks), 32'd0);
    last_rd = 32'd0;
    model_step(1'b0, 32'h20, 32'd0, exp_lat, exp_e, exp_rd);
    txn(1'b0, 1'b0, 32'h20, 32'd0, lat, e, rd, b1);
    check("rstw_read", rd, 32'd0);
    check("rstw_read_lat", 32'(lat), 32'(LAT));

    // reset in the RESP cycle: write already committed
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'h5A5A_0F0F;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("rsta_ack_before", 32'(ack), 32'd1);
    rst = 1'b0;
    #1;
    check("rsta_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_rd = 32'd0;
    model_step(1'b1, 32'h24, 32'h5A5A_0F0F, exp_lat, exp_e, exp_rd);
    model_step(1'b0, 32'h24, 32'd0, exp_lat, exp_e, exp_rd);
    txn(1'b0, 1'b0, 32'h24, 32'd0, lat, e, rd, b1);
    check("rsta_read", rd, 32'h5A5A_0F0F);

    // zero-wait-state instance
    txn(1'b1, 1'b1, 32'h4, 32'd7, lat, e, rd, b1);
    check("w0_wr_lat", 32'(lat), 32'd2);
    txn(1'b1, 1'b0, 32'h4, 32'd0, lat, e, rd, b1);
    check("w0_rd_lat", 32'(lat), 32'd2);
    check("w0_rdata", rd, 32'd7);
    txn(1'b1, 1'b0, 32'h5, 32'd0, lat, e, rd, b1);
    check("w0_mis_lat", 32'(lat), 32'd1);
    check("w0_mis_err", 32'(e), 32'd1);
    check("w0_mis_rdata", rd, 32'd7);

    // debug port on word 4 (byte 0x10)
    model_step(1'b1, 32'h10, 32'hCAFE_0001, exp_lat, exp_e, exp_rd);
    txn(1'b0, 1'b1, 32'h10, 32'hCAFE_0001, lat, e, rd, b1);
    check("dbg_old", dbg_data, DBG_EN ? 32'hDEAD_BEEF : 32'd0);
    @(negedge clk);
    check("dbg_new", dbg_data, DBG_EN ? 32'hCAFE_0001 : 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      logic        w;
      logic [1:0]  mis;
      logic [31:0] a, d;
      int          word;
      w    = 1'($urandom_range(0, 1));
      word = int'($urandom_range(0, 15));
      mis  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (!w && (mis == 2'd0) && !model.exists(word)) w = 1'b1;
      a = $urandom;
      a[AW+1:2] = AW'(word);
      a[1:0] = mis;
      d = $urandom;
      model_step(w, a, d, exp_lat, exp_e, exp_rd);
      txn(1'b0, w, a, d, lat, e, rd, b1);
      check("rnd_lat", 32'(lat), 32'(exp_lat));
      check("rnd_err", 32'(e), 32'(exp_e));
      check("rnd_rdata", rd, exp_rd);
    end

    check("err_without_ack", 32'(stray), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
